// File: rtl/psk_samples_out_reg.sv
// Output register stage after the PSK phase accumulator: captures ROM samples in the packet window,
// packs PACK samples per word and streams words out of a FIFO. Macro PSK_OUT_REG_SAMPLE_CHECK_EN adds a sample-count check.
module psk_samples_out_reg #(
    parameter int SAMPLE_W    = 12,
    parameter int PACK        = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int ROM_LATENCY = 1,
    parameter logic [SAMPLE_W-1:0] PAD_VALUE = 12'd2048
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic [SAMPLE_W-1:0]      ROM_DATA,
    input  logic                     SIGN_START_CALC,
    input  logic                     SIGN_STOP_CALC,
    output logic                     OUT_REG_READY,
    output logic [SAMPLE_W*PACK-1:0] OUT_DATA,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic                     OVERFLOW,
    output logic [15:0]              WORD_CNT,
`ifdef PSK_OUT_REG_SAMPLE_CHECK_EN
    input  logic [31:0]              EXP_SAMPLES,
    output logic [31:0]              SAMPLE_CNT,
    output logic                     CNT_ERR,
`endif
    output logic [2:0]               DBG_STATE
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int LW = $clog2(ROM_LATENCY + 1);
    localparam int DW = SAMPLE_W * PACK;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_COLLECT = 3'd2,
        S_FLUSH   = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic                   start_q;
    logic                   start_rise;
    logic                   start_fall;
    logic                   in_window;
    logic                   pkt_start;
    logic                   pad_now;
    logic [ROM_LATENCY-1:0] win_d;
    logic                   capture;
    logic [LW-1:0]          flush_cnt;

    logic [SAMPLE_W-1:0]    pack_buf [PACK];
    logic [IW-1:0]          pack_idx;
    logic                   wr_req;
    logic [DW-1:0]          wr_data;

    logic [DW-1:0]          mem [FIFO_DEPTH];
    logic [AW:0]            wr_ptr, rd_ptr;
    logic [AW:0]            wr_nxt, rd_nxt;
    logic                   fifo_empty, fifo_full;
    logic                   pop, wr_ok, drop;
    logic                   out_valid;
    logic [DW-1:0]          out_data;

    assign start_rise = SIGN_START_CALC & ~start_q;
    assign start_fall = ~SIGN_START_CALC & start_q;
    assign capture    = win_d[ROM_LATENCY-1];

    // ---------------- control FSM ----------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= S_IDLE;
            start_q   <= 1'b0;
            flush_cnt <= '0;
        end else begin
            state   <= state_nxt;
            start_q <= SIGN_START_CALC;
            if (state == S_FLUSH) flush_cnt <= flush_cnt + LW'(1);
            else                  flush_cnt <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        in_window = 1'b0;
        pkt_start = 1'b0;
        pad_now   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_rise) begin
                    state_nxt = S_ARMED;
                    pkt_start = 1'b1;
                end
            end
            S_ARMED: begin
                // A STOP coinciding with the START fall is a one-sample packet.
                if (start_fall) begin
                    in_window = 1'b1;
                    state_nxt = SIGN_STOP_CALC ? S_FLUSH : S_COLLECT;
                end
            end
            S_COLLECT: begin
                in_window = 1'b1;
                if (SIGN_STOP_CALC) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if (flush_cnt == LW'(ROM_LATENCY)) begin
                    pad_now   = (pack_idx != '0);
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fifo_empty) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ROM data for an address shows up ROM_LATENCY cycles later.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            win_d <= '0;
        end else begin
            win_d[0] <= in_window;
            for (int i = 1; i < ROM_LATENCY; i++) win_d[i] <= win_d[i-1];
        end
    end

    // ---------------- sample packing ----------------
    always_comb begin
        wr_req  = 1'b0;
        wr_data = '0;
        if (capture && pack_idx == IW'(PACK - 1)) begin
            wr_req = 1'b1;
            for (int i = 0; i < PACK; i++)
                wr_data[i*SAMPLE_W +: SAMPLE_W] = (IW'(i) == pack_idx) ? ROM_DATA : pack_buf[i];
        end else if (pad_now) begin
            wr_req = 1'b1;
            for (int i = 0; i < PACK; i++)
                wr_data[i*SAMPLE_W +: SAMPLE_W] = (IW'(i) < pack_idx) ? pack_buf[i] : PAD_VALUE;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pack_idx <= '0;
            for (int i = 0; i < PACK; i++) pack_buf[i] <= '0;
        end else if (pkt_start) begin
            pack_idx <= '0;
        end else if (capture) begin
            pack_buf[pack_idx] <= ROM_DATA;
            pack_idx           <= pack_idx + IW'(1);
        end else if (pad_now) begin
            pack_idx <= '0;
        end
    end

    // ---------------- word FIFO ----------------
    // Valid/ready: a word moves downstream in every cycle where OUT_VALID and OUT_READY are both high;
    // OUT_DATA is stable while OUT_VALID is high and OUT_READY is low.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = out_valid & OUT_READY;
    assign wr_ok      = wr_req & (~fifo_full | pop);
    assign drop       = wr_req & ~wr_ok;
    assign rd_nxt     = rd_ptr + {{AW{1'b0}}, pop};
    assign wr_nxt     = wr_ptr + {{AW{1'b0}}, wr_ok};

    always_ff @(posedge CLK) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // The output register mirrors the head entry; the head slot is counted in the FIFO depth.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            wr_ptr    <= wr_nxt;
            rd_ptr    <= rd_nxt;
            out_valid <= (wr_nxt != rd_nxt);
            if (wr_nxt != rd_nxt) begin
                if (wr_ok && wr_ptr[AW-1:0] == rd_nxt[AW-1:0]) out_data <= wr_data;
                else                                           out_data <= mem[rd_nxt[AW-1:0]];
            end
        end
    end

    // ---------------- status ----------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            OVERFLOW <= 1'b0;
            WORD_CNT <= '0;
        end else if (pkt_start) begin
            OVERFLOW <= 1'b0;
            WORD_CNT <= '0;
        end else begin
            if (drop) OVERFLOW <= 1'b1;
            if (wr_ok && WORD_CNT != 16'hFFFF) WORD_CNT <= WORD_CNT + 16'd1;
        end
    end

`ifdef PSK_OUT_REG_SAMPLE_CHECK_EN
    logic [31:0] exp_samples_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            exp_samples_q <= '0;
            SAMPLE_CNT    <= '0;
            CNT_ERR       <= 1'b0;
        end else if (pkt_start) begin
            exp_samples_q <= EXP_SAMPLES;
            SAMPLE_CNT    <= '0;
            CNT_ERR       <= 1'b0;
        end else begin
            if (capture) SAMPLE_CNT <= SAMPLE_CNT + 32'd1;
            if (state == S_FLUSH && state_nxt == S_DRAIN)
                CNT_ERR <= (SAMPLE_CNT != exp_samples_q);
        end
    end
`endif

    assign OUT_REG_READY = (state == S_IDLE) && fifo_empty;
    assign OUT_VALID     = out_valid;
    assign OUT_DATA      = out_data;
    assign DBG_STATE     = state;

endmodule

// File: tb/tb_psk_samples_out_reg.sv
// Directed bench for psk_samples_out_reg: packet table, latency/hold, overflow and reset sequences.
module tb_psk_samples_out_reg;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [11:0] ROM_DATA = '0;
    logic        SIGN_START_CALC = 1'b0;
    logic        SIGN_STOP_CALC = 1'b0;
    logic        OUT_REG_READY;
    logic [47:0] OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;
    logic        OVERFLOW;
    logic [15:0] WORD_CNT;
    logic [2:0]  DBG_STATE;
`ifdef PSK_OUT_REG_SAMPLE_CHECK_EN
    logic [31:0] EXP_SAMPLES = '0;
    logic [31:0] SAMPLE_CNT;
    logic        CNT_ERR;
`endif

    psk_samples_out_reg dut (
        .CLK             (CLK),
        .RESET_N         (RESET_N),
        .ROM_DATA        (ROM_DATA),
        .SIGN_START_CALC (SIGN_START_CALC),
        .SIGN_STOP_CALC  (SIGN_STOP_CALC),
        .OUT_REG_READY   (OUT_REG_READY),
        .OUT_DATA        (OUT_DATA),
        .OUT_VALID       (OUT_VALID),
        .OUT_READY       (OUT_READY),
        .OVERFLOW        (OVERFLOW),
        .WORD_CNT        (WORD_CNT),
`ifdef PSK_OUT_REG_SAMPLE_CHECK_EN
        .EXP_SAMPLES     (EXP_SAMPLES),
        .SAMPLE_CNT      (SAMPLE_CNT),
        .CNT_ERR         (CNT_ERR),
`endif
        .DBG_STATE       (DBG_STATE)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- scoreboard ----------------
    logic [47:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int rx_cnt   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge CLK) begin
        if (RESET_N && OUT_VALID && OUT_READY) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL word_unexpected: got %0h expected no word", OUT_DATA);
            end else begin
                check("word", {16'd0, OUT_DATA}, {16'd0, exp_q.pop_front()});
            end
            rx_cnt++;
        end
    end

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [11:0] smp(input logic [11:0] base, input logic [11:0] stp, input int k);
        return base + 12'(k) * stp;
    endfunction

    // ROM model with one cycle of latency: address k's data is driven in cycle k+1.
    task automatic send_packet(input int n, input logic [11:0] base, input logic [11:0] stp,
                               input int start_cyc);
        SIGN_START_CALC = 1'b1;
        repeat (start_cyc) step();
        for (int k = 0; k < n; k++) begin
            SIGN_START_CALC = 1'b0;
            SIGN_STOP_CALC  = (k == n - 1);
            ROM_DATA        = (k > 0) ? smp(base, stp, k - 1) : 12'd0;
            step();
        end
        SIGN_STOP_CALC = 1'b0;
        ROM_DATA       = smp(base, stp, n - 1);
        step();
        ROM_DATA = '0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (OUT_REG_READY) break;
            step();
        end
        check("reach_idle", {63'd0, OUT_REG_READY}, 64'd1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          n;
        logic [11:0] base;
        logic [11:0] stp;
        int          start_cyc;
        int          n_words;
        logic [47:0] w0;
        logic [47:0] w1;
        logic [15:0] exp_wc;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [11:0] hs[4];

        vecs[0] = '{8, 12'h001, 12'h001, 25, 2, 48'h004003002001, 48'h008007006005, 16'd2};
        vecs[1] = '{6, 12'h001, 12'h001, 4,  2, 48'h004003002001, 48'h800800006005, 16'd2};
        vecs[2] = '{1, 12'hABC, 12'h000, 3,  1, 48'h800800800ABC, 48'h0,            16'd1};
        vecs[3] = '{4, 12'h111, 12'h111, 2,  1, 48'h444333222111, 48'h0,            16'd1};
        vecs[4] = '{5, 12'hFFF, 12'h001, 6,  2, 48'h002001000FFF, 48'h800800800003, 16'd2};
        hs = '{12'h0A1, 12'h0B2, 12'h0C3, 12'h0D4};

        // Reset values
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ready",    {63'd0, OUT_REG_READY}, 64'd1);
        check("rst_valid",    {63'd0, OUT_VALID}, 64'd0);
        check("rst_data",     {16'd0, OUT_DATA}, 64'd0);
        check("rst_overflow", {63'd0, OVERFLOW}, 64'd0);
        check("rst_wordcnt",  {48'd0, WORD_CNT}, 64'd0);
        check("rst_state",    {61'd0, DBG_STATE}, 64'd0);
        RESET_N = 1'b1;
        step();

        // STOP outside COLLECT is ignored
        SIGN_STOP_CALC = 1'b1;
        step();
        SIGN_STOP_CALC = 1'b0;
        step();
        check("stop_in_idle_state", {61'd0, DBG_STATE}, 64'd0);
        check("stop_in_idle_valid", {63'd0, OUT_VALID}, 64'd0);

        // Handshake, 1-cycle word latency and hold under backpressure
        OUT_READY = 1'b0;
        rx_cnt    = 0;
        exp_q.push_back(48'h0D40C30B20A1);
        SIGN_START_CALC = 1'b1;
        check("ready_at_start", {63'd0, OUT_REG_READY}, 64'd1);
        step();
        check("ready_drop", {63'd0, OUT_REG_READY}, 64'd0);
        check("state_armed", {61'd0, DBG_STATE}, 64'd1);
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            SIGN_START_CALC = 1'b0;
            SIGN_STOP_CALC  = (k == 3);
            ROM_DATA        = (k > 0) ? hs[k-1] : 12'd0;
            step();
        end
        SIGN_STOP_CALC = 1'b0;
        ROM_DATA       = hs[3];
        check("state_flush", {61'd0, DBG_STATE}, 64'd3);
        check("valid_before_4th", {63'd0, OUT_VALID}, 64'd0);
        step();
        ROM_DATA = '0;
        check("valid_after_4th", {63'd0, OUT_VALID}, 64'd1);
        check("data_after_4th", {16'd0, OUT_DATA}, {16'd0, 48'h0D40C30B20A1});
        repeat (3) step();
        check("data_hold", {16'd0, OUT_DATA}, {16'd0, 48'h0D40C30B20A1});
        check("state_drain", {61'd0, DBG_STATE}, 64'd4);
        check("ready_in_drain", {63'd0, OUT_REG_READY}, 64'd0);
        OUT_READY = 1'b1;
        wait_idle(20);
        check("latency_rx", rx_cnt, 1);

        // Overflow: 72 samples with the sink stalled, only 16 words fit
        OUT_READY = 1'b0;
        rx_cnt    = 0;
        for (int i = 0; i < 16; i++)
            exp_q.push_back({12'(4*i+4), 12'(4*i+3), 12'(4*i+2), 12'(4*i+1)});
        send_packet(72, 12'h001, 12'h001, 5);
        repeat (4) step();
        check("ovf_flag",    {63'd0, OVERFLOW}, 64'd1);
        check("ovf_wordcnt", {48'd0, WORD_CNT}, 64'd16);
        check("ovf_state",   {61'd0, DBG_STATE}, 64'd4);
        check("ovf_ready",   {63'd0, OUT_REG_READY}, 64'd0);
        OUT_READY = 1'b1;
        wait_idle(100);
        check("ovf_rx", rx_cnt, 16);
        check("ovf_queue_empty", exp_q.size(), 0);

        // Asynchronous reset clears sticky status while idle
        #2 RESET_N = 1'b0;
        #1;
        check("arst_overflow", {63'd0, OVERFLOW}, 64'd0);
        check("arst_wordcnt",  {48'd0, WORD_CNT}, 64'd0);
        step();
        RESET_N = 1'b1;
        step();

        // Reset in the middle of COLLECT with one word pending
        OUT_READY       = 1'b0;
        SIGN_START_CALC = 1'b1;
        repeat (2) step();
        for (int k = 0; k < 7; k++) begin
            SIGN_START_CALC = 1'b0;
            ROM_DATA        = (k > 0) ? 12'(k) : 12'd0;
            step();
        end
        check("mid_state_collect", {61'd0, DBG_STATE}, 64'd2);
        check("mid_wordcnt", {48'd0, WORD_CNT}, 64'd1);
        check("mid_valid", {63'd0, OUT_VALID}, 64'd1);
        #2 RESET_N = 1'b0;
        #1;
        check("mid_rst_ready",   {63'd0, OUT_REG_READY}, 64'd1);
        check("mid_rst_valid",   {63'd0, OUT_VALID}, 64'd0);
        check("mid_rst_data",    {16'd0, OUT_DATA}, 64'd0);
        check("mid_rst_wordcnt", {48'd0, WORD_CNT}, 64'd0);
        check("mid_rst_state",   {61'd0, DBG_STATE}, 64'd0);
        ROM_DATA = '0;
        step();
        RESET_N   = 1'b1;
        OUT_READY = 1'b1;
        step();

        // Packet table
        for (int v = 0; v < 5; v++) begin
            rx_cnt = 0;
            exp_q.push_back(vecs[v].w0);
            if (vecs[v].n_words > 1) exp_q.push_back(vecs[v].w1);
            send_packet(vecs[v].n, vecs[v].base, vecs[v].stp, vecs[v].start_cyc);
            wait_idle(50);
            check("tbl_rx",       rx_cnt, vecs[v].n_words);
            check("tbl_wordcnt",  {48'd0, WORD_CNT}, {48'd0, vecs[v].exp_wc});
            check("tbl_overflow", {63'd0, OVERFLOW}, 64'd0);
            check("tbl_state",    {61'd0, DBG_STATE}, 64'd0);
            step();
        end

`ifdef PSK_OUT_REG_SAMPLE_CHECK_EN
        EXP_SAMPLES = 32'd8;
        exp_q.push_back(48'h004003002001);
        exp_q.push_back(48'h800007006005);
        send_packet(7, 12'h001, 12'h001, 3);
        wait_idle(50);
        check("cnt_err_set",  {63'd0, CNT_ERR}, 64'd1);
        check("sample_cnt_7", {32'd0, SAMPLE_CNT}, 64'd7);
        exp_q.push_back(48'h004003002001);
        exp_q.push_back(48'h008007006005);
        send_packet(8, 12'h001, 12'h001, 3);
        wait_idle(50);
        check("cnt_err_clr",  {63'd0, CNT_ERR}, 64'd0);
        check("sample_cnt_8", {32'd0, SAMPLE_CNT}, 64'd8);
`endif

        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
